// File: rtl/niosii_cpu_debug_mem.sv
// niosii_cpu_debug_mem
//   Debug RAM (2^ADDR_W x 32, single port, registered read) shared between the
//   JTAG debug path and a CPU-side Avalon-MM slave. JTAG strobes always win the
//   RAM port; the CPU is stalled through cpu_waitrequest when it loses.
//
// Ports
//   clk, reset_n              system clock, synchronous active-low reset
//   jdo[37:0]                 JTAG payload: [34:3] write data, [25:18] address,
//                             [17] read-after-set-address
//   take_action_ocimem_a      set address (optionally read)
//   take_no_action_ocimem_a   read at current address, post-increment
//   take_action_ocimem_b      write at current address, post-increment
//   cpu_*                     Avalon-MM slave (word addressed, byte enables)
//   MonDReg, monitor_ready    last JTAG read result and its valid flag
//   write_violation           pulse when a CPU write without debugaccess is dropped
module niosii_cpu_debug_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  input  logic              cpu_debugaccess,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              write_violation
);

  logic [31:0]       ram [2**ADDR_W];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] mon_a;
  logic              cpu_rd_pend;
  logic              jtag_rd_pend;
  logic [31:0]       readdata_hold;

  logic              jtag_strobe;
  logic              cpu_grant;
  logic              grant_rd;
  logic              grant_wr;
  logic              jtag_rd_issue;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign jtag_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // Nothing is granted while in reset so that a held CPU request stalls and
  // no stray write lands in the RAM.
  assign cpu_grant   = reset_n & ~jtag_strobe & ~cpu_rd_pend & (cpu_read | cpu_write);
  assign grant_wr    = cpu_grant & cpu_write;
  assign grant_rd    = cpu_grant & cpu_read & ~cpu_write;

  assign cpu_waitrequest = (cpu_read | cpu_write) & ~(grant_wr | (cpu_rd_pend & cpu_read));
  // Read data is exposed straight from ram_q in the completion cycle, then held.
  assign cpu_readdata    = cpu_rd_pend ? ram_q : readdata_hold;

  // RAM port arbitration: ocimem_a > ocimem_b > no_action_a > CPU
  always_comb begin
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = cpu_address;
    ram_wdata     = cpu_writedata;
    ram_be        = cpu_byteenable;
    jtag_rd_issue = 1'b0;
    if (!reset_n) begin
      ram_we = 1'b0;
    end else if (take_action_ocimem_a) begin
      ram_addr      = jdo[18 +: ADDR_W];
      ram_re        = jdo[17];
      jtag_rd_issue = jdo[17];
    end else if (take_action_ocimem_b) begin
      ram_addr  = mon_a;
      ram_we    = 1'b1;
      ram_wdata = jdo[34:3];
      ram_be    = 4'hF;
    end else if (take_no_action_ocimem_a) begin
      ram_addr      = mon_a;
      ram_re        = 1'b1;
      jtag_rd_issue = 1'b1;
    end else if (cpu_grant) begin
      ram_we = cpu_write & cpu_debugaccess;
      ram_re = grant_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_re) ram_q <= ram[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mon_a           <= '0;
      MonDReg         <= '0;
      monitor_ready   <= 1'b0;
      readdata_hold   <= '0;
      write_violation <= 1'b0;
      cpu_rd_pend     <= 1'b0;
      jtag_rd_pend    <= 1'b0;
    end else begin
      // Retire pending reads first; a new strobe below may override monitor_ready.
      if (jtag_rd_pend) begin
        MonDReg       <= ram_q;
        monitor_ready <= 1'b1;
      end
      if (cpu_rd_pend) readdata_hold <= ram_q;

      if (take_action_ocimem_a) begin
        mon_a         <= jdo[18 +: ADDR_W];
        monitor_ready <= 1'b0;
      end else if (take_action_ocimem_b) begin
        mon_a <= mon_a + ADDR_W'(1);
      end else if (take_no_action_ocimem_a) begin
        mon_a         <= mon_a + ADDR_W'(1);
        monitor_ready <= 1'b0;
      end

      jtag_rd_pend    <= jtag_rd_issue;
      cpu_rd_pend     <= grant_rd;
      write_violation <= grant_wr & ~cpu_debugaccess;
    end
  end

endmodule

// File: tb/tb_niosii_cpu_debug_mem.sv
module tb_niosii_cpu_debug_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_debugaccess;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        write_violation;

  int checks = 0;
  int errors = 0;

  niosii_cpu_debug_mem #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_debugaccess         (cpu_debugaccess),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .write_violation         (write_violation)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic jtag_a(input logic [7:0] addr, input logic rd);
    jdo = '0;
    jdo[25:18] = addr;
    jdo[17] = rd;
    take_action_ocimem_a = 1'b1;
    tick;
    take_action_ocimem_a = 1'b0;
    tick;
  endtask

  task automatic jtag_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_action_ocimem_b = 1'b1;
    tick;
    take_action_ocimem_b = 1'b0;
    tick;
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic dbg, input string tag);
    cpu_address = addr; cpu_writedata = data; cpu_byteenable = be;
    cpu_debugaccess = dbg; cpu_write = 1'b1;
    #1;
    chk({tag, "_wait"}, {31'd0, cpu_waitrequest}, 32'd0);
    tick;
    cpu_write = 1'b0;
    chk({tag, "_viol"}, {31'd0, write_violation}, {31'd0, ~dbg});
    tick;
    chk({tag, "_viol_end"}, {31'd0, write_violation}, 32'd0);
  endtask

  task automatic cpu_rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    cpu_address = addr; cpu_read = 1'b1;
    #1;
    chk({tag, "_wait_grant"}, {31'd0, cpu_waitrequest}, 32'd1);
    tick;
    chk({tag, "_wait_done"}, {31'd0, cpu_waitrequest}, 32'd0);
    chk({tag, "_data"}, cpu_readdata, exp);
    cpu_read = 1'b0;
    tick;
    chk({tag, "_hold"}, cpu_readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; jdo = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    cpu_address = '0; cpu_read = 1'b1; cpu_write = 0; cpu_writedata = '0;
    cpu_byteenable = 4'hF; cpu_debugaccess = 1'b1;

    // Reset with a CPU read held
    tick; tick;
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_mready", {31'd0, monitor_ready}, 32'd0);
    chk("rst_rdata", cpu_readdata, 32'd0);
    chk("rst_viol", {31'd0, write_violation}, 32'd0);
    chk("rst_wait", {31'd0, cpu_waitrequest}, 32'd1);
    reset_n = 1'b1;
    #1;
    chk("rel_wait_grant", {31'd0, cpu_waitrequest}, 32'd1);
    tick;
    chk("rel_wait_done", {31'd0, cpu_waitrequest}, 32'd0);
    cpu_read = 1'b0;
    tick;

    // JTAG write then readback at 0x10
    jtag_a(8'h10, 1'b0);
    jtag_b(32'hDEADBEEF);
    jdo = '0; jdo[25:18] = 8'h10; jdo[17] = 1'b1;
    take_action_ocimem_a = 1'b1;
    tick;
    take_action_ocimem_a = 1'b0;
    chk("jrd_mready_pend", {31'd0, monitor_ready}, 32'd0);
    tick;
    chk("jrd_mready", {31'd0, monitor_ready}, 32'd1);
    chk("jrd_mondreg", MonDReg, 32'hDEADBEEF);
    // MonAReg must still be 0x10: overwrite there and read it back from the CPU side
    jtag_b(32'hCAFEF00D);
    chk("jwr_mready_kept", {31'd0, monitor_ready}, 32'd1);
    cpu_rd(8'h10, 32'hCAFEF00D, "areg10");

    // Auto-increment wrap from 0xFF
    jtag_a(8'hFF, 1'b0);
    chk("wrap_mready_clr", {31'd0, monitor_ready}, 32'd0);
    jtag_b(32'h1);
    jtag_b(32'h2);
    jtag_b(32'h3);
    cpu_rd(8'hFF, 32'h1, "wrap_ff");
    cpu_rd(8'h00, 32'h2, "wrap_00");
    cpu_rd(8'h01, 32'h3, "wrap_01");

    // CPU byte-enabled write, read, and a dropped write
    cpu_wr(8'h05, 32'hFFFFFFFF, 4'hF, 1'b1, "cw_fill");
    cpu_wr(8'h05, 32'h12345678, 4'b0011, 1'b1, "cw_be");
    cpu_rd(8'h05, 32'hFFFF5678, "cr_be");
    cpu_wr(8'h05, 32'h00000000, 4'hF, 1'b0, "cw_viol");
    cpu_rd(8'h05, 32'hFFFF5678, "cr_after_viol");

    // Collision: CPU read in the same cycle as take_no_action_ocimem_a
    cpu_wr(8'h07, 32'h77777777, 4'hF, 1'b1, "cw_07");
    jtag_a(8'h20, 1'b0);
    jtag_b(32'hA5A5A5A5);
    jtag_a(8'h20, 1'b0);
    cpu_address = 8'h07; cpu_read = 1'b1; take_no_action_ocimem_a = 1'b1;
    #1;
    chk("col_wait_c1", {31'd0, cpu_waitrequest}, 32'd1);
    tick;
    take_no_action_ocimem_a = 1'b0;
    chk("col_wait_c2", {31'd0, cpu_waitrequest}, 32'd1);
    tick;
    chk("col_wait_c3", {31'd0, cpu_waitrequest}, 32'd0);
    chk("col_rdata", cpu_readdata, 32'h77777777);
    chk("col_mondreg", MonDReg, 32'hA5A5A5A5);
    chk("col_mready", {31'd0, monitor_ready}, 32'd1);
    cpu_read = 1'b0;
    tick;

    // JTAG strobe issued during the CPU completion cycle
    jtag_a(8'h21, 1'b0);
    jtag_b(32'h21212121);
    jtag_a(8'h21, 1'b0);
    cpu_address = 8'h05; cpu_read = 1'b1;
    #1;
    chk("pend_wait_grant", {31'd0, cpu_waitrequest}, 32'd1);
    tick;
    chk("pend_wait_done", {31'd0, cpu_waitrequest}, 32'd0);
    chk("pend_rdata", cpu_readdata, 32'hFFFF5678);
    take_no_action_ocimem_a = 1'b1;
    tick;
    take_no_action_ocimem_a = 1'b0; cpu_read = 1'b0;
    chk("pend_rdata_hold", cpu_readdata, 32'hFFFF5678);
    chk("pend_mready_clr", {31'd0, monitor_ready}, 32'd0);
    tick;
    chk("pend_mondreg", MonDReg, 32'h21212121);
    chk("pend_mready", {31'd0, monitor_ready}, 32'd1);
    chk("pend_rdata_final", cpu_readdata, 32'hFFFF5678);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
